// File: rtl/imem_fetch_ctrl_if.sv
// imem_fetch_ctrl_if: imem bus, redirect and decode handshake of the fetch sequencer (FETCH_PERF_CNT_EN adds perf counters)
interface imem_fetch_ctrl_if;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        fetch_fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
    modport master (
        output imem_addr, if_valid, if_pc, if_instr, fetch_fault, perf_fetched, perf_flushed,
        input  imem_rdata, redirect_valid, redirect_pc, if_ready
    );
    modport slave (
        input  imem_addr, if_valid, if_pc, if_instr, fetch_fault, perf_fetched, perf_flushed,
        output imem_rdata, redirect_valid, redirect_pc, if_ready
    );
`else
    modport master (
        output imem_addr, if_valid, if_pc, if_instr, fetch_fault,
        input  imem_rdata, redirect_valid, redirect_pc, if_ready
    );
    modport slave (
        input  imem_addr, if_valid, if_pc, if_instr, fetch_fault,
        output imem_rdata, redirect_valid, redirect_pc, if_ready
    );
`endif
endinterface

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: imem fetch sequencer with 2-entry queue, redirect flush and fault stop (FETCH_PERF_CNT_EN adds perf counters)
module imem_fetch_ctrl #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          IMEM_BYTES = 88,
    parameter int          QDEPTH     = 2
) (
    input logic               clk,
    input logic               reset,
    imem_fetch_ctrl_if.master bus
);
    typedef enum logic {RUN, FAULT} state_t;
    state_t      state, state_nx;
    logic [63:0] fetch_pc, last_pc;
    logic [31:0] last_instr;
    logic [63:0] pc_q [QDEPTH];
    logic [31:0] instr_q [QDEPTH];
    logic        rd_ptr, wr_ptr, full, empty, bad, pop, push;
    always_comb begin
        empty    = (rd_ptr == wr_ptr) && !full;
        bad      = (fetch_pc[1:0] != 2'b00) || (fetch_pc + 64'd3 >= 64'(IMEM_BYTES));
        pop      = !empty && bus.if_ready && !bus.redirect_valid;
        push     = (state == RUN) && !bus.redirect_valid && !bad && (!full || pop);
        state_nx = bus.redirect_valid ? RUN : (state == RUN && bad) ? FAULT : state;
    end
    assign bus.imem_addr   = fetch_pc;
    assign bus.if_valid    = !empty;
    assign bus.if_pc       = empty ? last_pc : pc_q[rd_ptr];
    assign bus.if_instr    = empty ? last_instr : instr_q[rd_ptr];
    assign bus.fetch_fault = (state == FAULT) && empty;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            fetch_pc   <= RESET_PC;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            full       <= 1'b0;
            last_pc    <= 64'd0;
            last_instr <= 32'd0;
        end else begin
            state <= state_nx;
            if (!empty) begin
                last_pc    <= bus.if_pc;
                last_instr <= bus.if_instr;
            end
            if (bus.redirect_valid) begin
                fetch_pc <= bus.redirect_pc;
                rd_ptr   <= wr_ptr;
                full     <= 1'b0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + 64'd4;
                    wr_ptr   <= !wr_ptr;
                end
                if (pop)
                    rd_ptr <= !rd_ptr;
                if (push != pop)
                    full <= push && (!wr_ptr == rd_ptr);
            end
        end
    end
    // storage needs no reset: pointers and full flag define what is live
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]    <= fetch_pc;
            instr_q[wr_ptr] <= bus.imem_rdata;
        end
    end
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched, flushed;
    logic [32:0] fet_sum, flu_sum;
    logic [1:0]  occ;
    always_comb begin
        occ     = full ? 2'd2 : {1'b0, !empty};
        fet_sum = {1'b0, fetched} + {32'd0, push};
        flu_sum = {1'b0, flushed} + (bus.redirect_valid ? {31'd0, occ} : 33'd0);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            fetched <= 32'd0;
            flushed <= 32'd0;
        end else begin
            fetched <= fet_sum[32] ? 32'hFFFF_FFFF : fet_sum[31:0];
            flushed <= flu_sum[32] ? 32'hFFFF_FFFF : flu_sum[31:0];
        end
    end
    assign bus.perf_fetched = fetched;
    assign bus.perf_flushed = flushed;
`endif
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: scoreboard bench; each reset/redirect queues the PC stream decode must receive.
module tb_imem_fetch_ctrl;
    localparam int          IMEM_BYTES = 88;
    localparam logic [63:0] RESET_PC   = 64'h0;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    imem_fetch_ctrl_if bus();
    imem_fetch_ctrl #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES), .QDEPTH(2)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    assign bus.imem_rdata = 32'hA000_0000 | bus.imem_addr[31:0];
    logic [63:0] stim_q [$];
    logic [63:0] stim_pc, stim_end, pend_pc, ac_val;
    logic        pend = 1'b0;
    int          rb_seq = 0;
    int          ac_seq = 0;
    logic [63:0] exp_q [$];
    logic [63:0] addr0, end_pc;
    int          since = 0;
    int          rb_seen = 0;
    int          ac_seen = 0;
    logic        rst_d = 1'b0;
    int          checks = 0;
    int          errors = 0;
    // a stream from p delivers every aligned in-range word from p upward, then faults at the first bad PC
    task automatic plan(input logic [63:0] p);
        stim_q.delete();
        stim_pc  = p;
        stim_end = p;
        if (p[1:0] == 2'b00)
            while (stim_end + 64'd3 < 64'(IMEM_BYTES)) begin
                stim_q.push_back(stim_end);
                stim_end += 64'd4;
            end
        rb_seq++;
    endtask
    task automatic step(input logic r, input logic rv, input logic [63:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        if (!r && reset)
            plan(RESET_PC);
        else if (!r && pend)
            plan(pend_pc);
        pend               = rv && !r;
        pend_pc            = rpc;
        reset              = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.if_ready       = rdy;
    endtask
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask
    always @(negedge clk) begin
        if (rb_seq != rb_seen) begin
            rb_seen = rb_seq;
            exp_q   = stim_q;
            addr0   = stim_pc;
            end_pc  = stim_end;
            since   = 0;
        end
        if (reset) begin
            if (rst_d) begin
                chk("rst_valid", 64'(bus.if_valid), 64'd0);
                chk("rst_pc", bus.if_pc, 64'd0);
                chk("rst_instr", 64'(bus.if_instr), 64'd0);
                chk("rst_fault", 64'(bus.fetch_fault), 64'd0);
                chk("rst_addr", bus.imem_addr, RESET_PC);
`ifdef FETCH_PERF_CNT_EN
                chk("rst_fetched", 64'(bus.perf_fetched), 64'd0);
                chk("rst_flushed", 64'(bus.perf_flushed), 64'd0);
`endif
            end
        end else if (since == 0) begin
            chk("restart_valid", 64'(bus.if_valid), 64'd0);
            chk("restart_addr", bus.imem_addr, addr0);
        end else begin
            chk("valid", 64'(bus.if_valid), 64'(exp_q.size() != 0));
            chk("fault", 64'(bus.fetch_fault), 64'(exp_q.size() == 0));
            if (exp_q.size() != 0 && bus.if_valid) begin
                chk("if_pc", bus.if_pc, exp_q[0]);
                chk("if_instr", 64'(bus.if_instr), 64'(32'hA000_0000 | exp_q[0][31:0]));
            end else if (exp_q.size() == 0)
                chk("fault_addr", bus.imem_addr, end_pc);
            if (bus.if_valid && bus.if_ready && !bus.redirect_valid && exp_q.size() != 0)
                void'(exp_q.pop_front());
        end
        if (ac_seq != ac_seen) begin
            ac_seen = ac_seq;
            chk("stall_addr", bus.imem_addr, ac_val);
        end
        rst_d = reset;
        if (since < 2)
            since++;
    end
    initial begin
        logic        rv, rdy;
        logic [63:0] pc;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'd0;
        bus.if_ready       = 1'b0;
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        repeat (10) step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0);
        ac_val = 64'h8;
        ac_seq++;
        repeat (4) step(0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0);
        step(0, 1, 64'h40, 1);
        repeat (4) step(0, 0, 0, 1);
        step(0, 1, 64'h50, 1);
        repeat (6) step(0, 0, 0, 1);
        step(0, 1, 64'h0, 1);
        repeat (3) step(0, 0, 0, 1);
        step(0, 1, 64'h42, 1);
        repeat (3) step(0, 0, 0, 1);
        step(0, 1, 64'h0, 0);
        repeat (3) step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                step(1, 0, 0, rdy);
                step(1, 0, 0, rdy);
            end else begin
                rv = ($urandom_range(0, 19) == 0);
                case ($urandom_range(0, 2))
                    0:       pc = 64'($urandom_range(0, 21)) * 64'd4;
                    1:       pc = 64'($urandom_range(0, 95));
                    default: pc = {$urandom, $urandom};
                endcase
                step(0, rv, pc, rdy);
            end
        end
        repeat (3) step(0, 0, 0, 1);
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
